// File: rtl/mux_pkg.sv
// Shared types and helpers for the scanned multiplexer family.
package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mux_mode_e;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(n)) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_nx1_scan_scan_ctr.sv
// Round-robin pointer with per-channel dwell count; ptr is a flop output, updates the edge after step.
// No backpressure of its own: the owner only asserts step on an accepted sample.
module scan_ctr
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int DWELL = 1,
    localparam int SW   = clog2_min1(N),
    localparam int DW   = clog2_min1(DWELL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    input  logic          restart,
    output logic [SW-1:0] ptr
);

    logic [DW-1:0] dwell;

    // restart wins over step; owners never raise both in one cycle anyway
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            dwell <= '0;
        end else if (restart) begin
            ptr   <= '0;
            dwell <= '0;
        end else if (step) begin
            if (dwell == DW'(DWELL - 1)) begin
                dwell <= '0;
                ptr   <= (ptr == SW'(N - 1)) ? '0 : ptr + 1'b1;
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_scan.sv
// N:1 registered mux, manual select or round-robin scan; optional y_par under MUX_NX1_SCAN_PARITY_EN.
// Latency 1 cycle; one sample per cycle while out_ready is high.
// Backpressure: y holds while y_valid && !out_ready; samples offered during a stall are dropped.
module mux_nx1_scan
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int DWELL = 1,
    localparam int SW   = clog2_min1(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic           in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic           out_ready,
    output logic [W-1:0]   y,
    output logic           y_valid,
`ifdef MUX_NX1_SCAN_PARITY_EN
    output logic           y_par,
`endif
    output logic [SW-1:0]  cur_sel
);

    mux_mode_e     state, next_state;
    logic [SW-1:0] ptr;
    logic [SW-1:0] idx;
    logic [W-1:0]  sel_dat;
    logic          open_slot, load, step, restart;

    assign open_slot = !y_valid || out_ready;
    assign load      = in_valid && open_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MODE_MANUAL;
        else        state <= next_state;
    end

    // Index rule comes from the current state, so a load in a switching cycle uses the old rule.
    always_comb begin
        next_state = mode ? MODE_SCAN : MODE_MANUAL;
        idx        = sel;
        step       = 1'b0;
        restart    = 1'b0;
        case (state)
            MODE_MANUAL: restart = (next_state == MODE_SCAN);
            MODE_SCAN: begin
                idx  = ptr;
                step = load;
            end
            default: ;
        endcase
    end

    scan_ctr #(.N(N), .DWELL(DWELL)) u_scan_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (step),
        .restart (restart),
        .ptr     (ptr)
    );

    // Out-of-range indices match no channel and yield zero.
    always_comb begin
        sel_dat = '0;
        for (int c = 0; c < N; c++) begin
            if (idx == SW'(c)) sel_dat = in_data[c*W +: W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            y_valid <= 1'b0;
            cur_sel <= '0;
        end else if (load) begin
            y       <= sel_dat;
            y_valid <= 1'b1;
            cur_sel <= idx;
        end else if (out_ready) begin
            y_valid <= 1'b0;
        end
    end

`ifdef MUX_NX1_SCAN_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    y_par <= 1'b0;
        else if (load) y_par <= ^sel_dat;
    end
`endif

endmodule
